dmem_arbiter: RTL

- Sequences and shares the single-port word-addressed data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Arbitrates between the ports and runs each access as a short FSM.
- Turns byte-enabled partial stores into read-modify-write, because the memory only supports whole-word synchronous writes with a combinational read.
- Sits between the requesters and the memory's clk/we/a/wd/rd pins.

---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Brief    : Requester, response and memory-pin bundle for dmem_arbiter.
//             slave  = arbiter side, master = requesters + memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;
  // port 0 (core LSU)
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_be;
  logic        p0_gnt;
  logic        p0_done;
  // port 1 (debug / DMA loader)
  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_be;
  logic        p1_gnt;
  logic        p1_done;
  // shared response
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  // memory pins
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    input  mem_rd,
    output p0_gnt, p0_done, p1_gnt, p1_done,
    output rsp_rdata, rsp_err, busy,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    output mem_rd,
    input  p0_gnt, p0_done, p1_gnt, p1_done,
    input  rsp_rdata, rsp_err, busy,
    input  mem_we, mem_a, mem_wd
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Two-port arbiter/sequencer for a single-port word-addressed
//             data memory (sync write, combinational read). Partial stores
//             are turned into read-modify-write sequences.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_WORD_BITS = 10,
  parameter bit RR_EN          = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q;
  logic        port_q;      // port owning the current access
  logic        rr_last_q;   // port granted most recently
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        p0_done_q;
  logic        p1_done_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mem_we_q;
  logic [31:0] mem_a_q;
  logic [31:0] mem_wd_q;    // also serves as the RMW merge buffer

  logic        any_req_d;
  logic        sel_d;       // winning port when any_req_d
  logic        we_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;
  logic        in_range_d;
  logic [31:0] merged_d;

  // Arbitration and selection of the winner's request fields
  always_comb begin
    any_req_d = bus.p0_req | bus.p1_req;
    if (bus.p0_req && bus.p1_req) begin
      sel_d = RR_EN ? ~rr_last_q : 1'b0;
    end else begin
      sel_d = ~bus.p0_req;
    end
    we_d       = sel_d ? bus.p1_we    : bus.p0_we;
    addr_d     = (sel_d ? bus.p1_addr : bus.p0_addr) & ~32'h3;
    wdata_d    = sel_d ? bus.p1_wdata : bus.p0_wdata;
    be_d       = sel_d ? bus.p1_be    : bus.p0_be;
    in_range_d = (addr_d >> (ADDR_WORD_BITS + 2)) == 32'd0;
  end

  // Byte-lane merge of store data over the word just read
  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.mem_rd[8*i +: 8];
  end

  // Access sequencer: latches the granted request and drives memory/response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      port_q    <= 1'b0;
      rr_last_q <= 1'b1;          // port 0 wins the first tie
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_a_q   <= 32'h0;
      mem_wd_q  <= 32'h0;
    end else begin
      // pulses are one cycle unless re-asserted below
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            port_q    <= sel_d;
            rr_last_q <= sel_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            if (!in_range_d) begin
              rdata_q   <= 32'h0;
              err_q     <= 1'b1;
              p0_done_q <= ~sel_d;
              p1_done_q <= sel_d;
              state_q   <= S_DONE;
            end else if (!we_d) begin
              mem_a_q <= addr_d;
              state_q <= S_RD;
            end else if (be_d == 4'hF) begin
              mem_a_q  <= addr_d;
              mem_wd_q <= wdata_d;
              mem_we_q <= 1'b1;
              state_q  <= S_WR;
            end else if (be_d == 4'h0) begin
              // empty store: completes without touching memory
              rdata_q   <= 32'h0;
              err_q     <= 1'b0;
              p0_done_q <= ~sel_d;
              p1_done_q <= sel_d;
              state_q   <= S_DONE;
            end else begin
              mem_a_q <= addr_d;
              state_q <= S_RMW_RD;
            end
          end
        end
        S_RD: begin
          rdata_q   <= bus.mem_rd;
          err_q     <= 1'b0;
          p0_done_q <= ~port_q;
          p1_done_q <= port_q;
          state_q   <= S_DONE;
        end
        S_RMW_RD: begin
          mem_wd_q <= merged_d;
          mem_we_q <= 1'b1;
          state_q  <= S_WR;
        end
        S_WR: begin
          rdata_q   <= 32'h0;
          err_q     <= 1'b0;
          p0_done_q <= ~port_q;
          p1_done_q <= port_q;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.p0_gnt    = (state_q == S_IDLE) && any_req_d && !sel_d;
  assign bus.p1_gnt    = (state_q == S_IDLE) && any_req_d &&  sel_d;
  assign bus.p0_done   = p0_done_q;
  assign bus.p1_done   = p1_done_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wd    = mem_wd_q;

endmodule
`default_nettype wire
